gpio_edge_irq: RTL

- Edge-capture and interrupt stage that sits beside the 64-bit GPIO block on the secondary bus, watching the same PA/PB pins and turning pin transitions into latched, maskable interrupt requests.
- Sits on the Primary secondary-bus decode (Addr/Rd/Wr/DataRd), selected at its own 256-word window, e.g. Addr[23:8]==16'hffe3.
- Its Irq output is ORed by the top level into the cartridge interrupt request.

---
 rtl/gpio_edge_irq.sv | 107 ++++++++++
 1 files changed

// File: rtl/gpio_edge_irq.sv
// Pin edge capture with per-pin rise/fall enables, W1C pending and masked, registered Irq.
// Pin change reaches Pending 3 Clk edges after S1 setup; Irq follows one cycle later. No backpressure.
module gpio_edge_irq #(
  parameter int WIDTH  = 64,
  parameter int SETTLE = 3
) (
  input  logic             Clk,
  input  logic             ResetN,
  input  logic [3:0]       Addr,
  input  logic [15:0]      DataWr,
  output logic [15:0]      DataRd,
  input  logic             En,
  input  logic             Rd,
  input  logic             Wr,
  input  logic [WIDTH-1:0] Pins,
  output logic             Irq
);

  localparam int NW = WIDTH / 16;

  logic [WIDTH-1:0] s1, s2, prev;
  logic [WIDTH-1:0] rise_en, fall_en, mask, pending;
  logic [WIDTH-1:0] pending_nxt, clr, rise, fall;
  logic [2:0]       settle_cnt;
  logic             settled;
  logic             wr_en;
  logic [1:0]       sel;
  logic [3:0]       word_hit;

  assign wr_en    = En & Wr;
  assign sel      = Addr[3:2];
  assign word_hit = 4'b0001 << Addr[1:0];

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      s1   <= '0;
      s2   <= '0;
      prev <= '0;
    end else begin
      s1   <= Pins;
      s2   <= s1;
      prev <= s2;
    end
  end

  // Synchronizer resets to 0, so pins already high would look like rising edges.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN)
      settle_cnt <= 3'd0;
    else if (settle_cnt != 3'(SETTLE))
      settle_cnt <= settle_cnt + 3'd1;
  end

  assign settled = (settle_cnt >= 3'(SETTLE));
  assign rise    = settled ? (s2 & ~prev) : '0;
  assign fall    = settled ? (~s2 & prev) : '0;

  always_comb begin
    clr = '0;
    for (int w = 0; w < NW; w++)
      if (wr_en && sel == 2'd0 && word_hit[w])
        clr[w*16 +: 16] = DataWr;
  end

  // A new edge takes priority over a same-cycle clear.
  assign pending_nxt = (pending & ~clr) | (rise & rise_en) | (fall & fall_en);

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      rise_en <= '0;
      fall_en <= '0;
      mask    <= '0;
      pending <= '0;
      Irq     <= 1'b0;
    end else begin
      pending <= pending_nxt;
      Irq     <= |(pending & mask);
      for (int w = 0; w < NW; w++) begin
        if (wr_en && word_hit[w]) begin
          case (sel)
            2'd1:    rise_en[w*16 +: 16] <= DataWr;
            2'd2:    fall_en[w*16 +: 16] <= DataWr;
            2'd3:    mask[w*16 +: 16]    <= DataWr;
            default: ;
          endcase
        end
      end
    end
  end

  always_comb begin
    DataRd = 16'h0000;
    if (En && Rd) begin
      for (int w = 0; w < NW; w++) begin
        if (word_hit[w]) begin
          case (sel)
            2'd0:    DataRd = pending[w*16 +: 16];
            2'd1:    DataRd = rise_en[w*16 +: 16];
            2'd2:    DataRd = fall_en[w*16 +: 16];
            default: DataRd = mask[w*16 +: 16];
          endcase
        end
      end
    end
  end

endmodule
